// File: rtl/riscv_decode_pkg.sv
// Shared decode definitions: RV32I major opcodes, the immediate-format
// select code and the decoded-field bundle carried by the decode stage.
package riscv_decode_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Steers the downstream immediate-extension units.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CSR  = 3'd6
  } imm_sel_e;

  // Decoded fields of one instruction. The PC travels beside this bundle
  // because its width is a parameter of the stage.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [6:0]  imm_hi;
    logic [4:0]  imm_lo;
    logic [19:0] imm_u;
    imm_sel_e    imm_sel;
    logic        illegal;
  } decode_bundle_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field split and immediate-format classification of one
// RV32I instruction word. Raw slices only; no sign extension here.
// Optional CSR decode is enabled by defining DECODE_CSR_EN.
module instr_field_decode
  import riscv_decode_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t dec
);

  // Slice fields and classify the format from the opcode (and funct3 for SYSTEM)
  always_comb begin
    dec.opcode  = instr[6:0];
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.imm_i   = instr[31:20];
    dec.imm_hi  = instr[31:25];
    dec.imm_lo  = instr[11:7];
    dec.imm_u   = instr[31:12];
    dec.imm_sel = IMM_NONE;
    dec.illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: dec.imm_sel = IMM_I;
      OPC_STORE:            dec.imm_sel = IMM_S;
      OPC_BRANCH:           dec.imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:   dec.imm_sel = IMM_U;
      OPC_JAL:              dec.imm_sel = IMM_J;
      OPC_OP:               dec.imm_sel = IMM_NONE;
      OPC_SYSTEM: begin
`ifdef DECODE_CSR_EN
        // funct3 4 is reserved; 5-7 are the zimm CSR forms
        if (instr[14:12] == 3'd4) dec.illegal = 1'b1;
        else if (instr[14])       dec.imm_sel = IMM_CSR;
        else                      dec.imm_sel = IMM_I;
`else
        // Without CSR support only ECALL/EBREAK are recognised
        if (instr[14:12] == 3'd0) dec.imm_sel = IMM_I;
        else                      dec.illegal = 1'b1;
`endif
      end
      // Covers unknown opcodes and any instr[1:0] != 2'b11
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode_stage.sv
// Registered IF/ID decode stage: valid/ready input, main output register
// plus one skid register for full throughput under backpressure, and a
// synchronous flush for branch redirect. CSR decode via DECODE_CSR_EN.
module if_id_decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [11:0]     out_imm_i,
  output logic [6:0]      out_imm_hi,
  output logic [4:0]      out_imm_lo,
  output logic [19:0]     out_imm_u,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  decode_bundle_t  in_dec;
  decode_bundle_t  main_q, main_d, skid_q, skid_d;
  logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic            in_ready_q, in_ready_d;
  logic            accept, main_load;

  instr_field_decode u_dec (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign accept    = in_valid && in_ready_q;
  assign main_load = !main_vld_q || out_ready;

  // Next-state for main/skid registers; skid only fills while main is stalled
  always_comb begin
    main_d     = main_q;
    main_pc_d  = main_pc_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_load) begin
      if (skid_vld_q) begin
        // in_ready is low while skid is full, so no input competes here
        main_d     = skid_q;
        main_pc_d  = skid_pc_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_d    = in_dec;
          main_pc_d = in_pc;
        end
      end
    end else if (accept) begin
      skid_d     = in_dec;
      skid_pc_d  = in_pc;
      skid_vld_d = 1'b1;
    end
    in_ready_d = !skid_vld_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_pc_q  <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_pc_q  <= main_pc_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_vld_q;
  assign out_pc      = main_pc_q;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_imm_i   = main_q.imm_i;
  assign out_imm_hi  = main_q.imm_hi;
  assign out_imm_lo  = main_q.imm_lo;
  assign out_imm_u   = main_q.imm_u;
  assign out_imm_sel = main_q.imm_sel;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Self-checking bench for if_id_decode_stage: directed vector table,
// hand-written backpressure/flush/reset sequences and randomized traffic,
// all checked against a queue-based reference model.
module tb_if_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [6:0]  out_opcode, out_funct7, out_imm_hi;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_imm_lo;
  logic [2:0]  out_funct3, out_imm_sel;
  logic [11:0] out_imm_i;
  logic [19:0] out_imm_u;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_id_decode_stage #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm_i(out_imm_i),
    .out_imm_hi(out_imm_hi), .out_imm_lo(out_imm_lo), .out_imm_u(out_imm_u),
    .out_imm_sel(out_imm_sel), .out_illegal(out_illegal)
  );

  // Reference model: FIFO of accepted instructions (depth 2), in_ready = room left
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t mq[$];
  logic m_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {illegal, imm_sel} from the opcode table
  function automatic logic [3:0] ref_dec(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: return {1'b0, 3'd1};
      7'h23: return {1'b0, 3'd2};
      7'h63: return {1'b0, 3'd3};
      7'h37, 7'h17: return {1'b0, 3'd4};
      7'h6F: return {1'b0, 3'd5};
      7'h33: return {1'b0, 3'd0};
      7'h73: begin
        if (f3 == 3'd0) return {1'b0, 3'd1};
`ifdef DECODE_CSR_EN
        if (f3 >= 3'd1 && f3 <= 3'd3) return {1'b0, 3'd1};
        if (f3 >= 3'd5) return {1'b0, 3'd6};
`endif
        return {1'b1, 3'd0};
      end
      default: return {1'b1, 3'd0};
    endcase
  endfunction

  task automatic check_outs();
    ent_t e;
    logic [3:0] d;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    if (mq.size() > 0) begin
      e = mq[0];
      d = ref_dec(e.instr);
      chk("out_pc", out_pc, e.pc);
      chk("out_opcode", {25'b0, out_opcode}, {25'b0, e.instr[6:0]});
      chk("out_rd", {27'b0, out_rd}, {27'b0, e.instr[11:7]});
      chk("out_rs1", {27'b0, out_rs1}, {27'b0, e.instr[19:15]});
      chk("out_rs2", {27'b0, out_rs2}, {27'b0, e.instr[24:20]});
      chk("out_funct3", {29'b0, out_funct3}, {29'b0, e.instr[14:12]});
      chk("out_funct7", {25'b0, out_funct7}, {25'b0, e.instr[31:25]});
      chk("out_imm_i", {20'b0, out_imm_i}, {20'b0, e.instr[31:20]});
      chk("out_imm_hi", {25'b0, out_imm_hi}, {25'b0, e.instr[31:25]});
      chk("out_imm_lo", {27'b0, out_imm_lo}, {27'b0, e.instr[11:7]});
      chk("out_imm_u", {12'b0, out_imm_u}, {12'b0, e.instr[31:12]});
      chk("out_imm_sel", {29'b0, out_imm_sel}, {29'b0, d[2:0]});
      chk("out_illegal", {31'b0, out_illegal}, {31'b0, d[3]});
    end
  endtask

  // One clock: update the model at the edge, then check outputs at negedge
  task automatic tick();
    logic pop, take;
    pop  = (mq.size() > 0) && out_ready;
    take = in_valid && m_rdy;
    @(posedge clk);
    if (!rst_n || flush) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (take) mq.push_back('{in_instr, in_pc});
      m_rdy = (mq.size() < 2);
    end
    @(negedge clk);
    if (rst_n) check_outs();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  typedef struct {logic [31:0] instr; logic [2:0] sel; logic ill;} vec_t;
  vec_t vt[$];
  logic [6:0] opcs [12];

  initial begin
    vt.push_back('{32'h00500093, 3'd1, 1'b0}); // ADDI
    vt.push_back('{32'h00112023, 3'd2, 1'b0}); // SW
    vt.push_back('{32'hFE000EE3, 3'd3, 1'b0}); // BEQ
    vt.push_back('{32'h12345037, 3'd4, 1'b0}); // LUI
    vt.push_back('{32'h00002017, 3'd4, 1'b0}); // AUIPC
    vt.push_back('{32'h0000006F, 3'd5, 1'b0}); // JAL
    vt.push_back('{32'h00B50533, 3'd0, 1'b0}); // ADD
    vt.push_back('{32'h0000100F, 3'd1, 1'b0}); // FENCE.I
    vt.push_back('{32'h00000073, 3'd1, 1'b0}); // ECALL
    vt.push_back('{32'hFFFFFFFF, 3'd0, 1'b1});
    vt.push_back('{32'h00000010, 3'd0, 1'b1}); // low bits != 11
    vt.push_back('{32'h0002C073, 3'd0, 1'b1}); // SYSTEM funct3 4
`ifdef DECODE_CSR_EN
    vt.push_back('{32'h30529073, 3'd1, 1'b0}); // CSRRW
    vt.push_back('{32'h3050D073, 3'd6, 1'b0}); // CSRRWI
`else
    vt.push_back('{32'h30529073, 3'd0, 1'b1});
    vt.push_back('{32'h3050D073, 3'd0, 1'b1});
`endif
    opcs = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
             7'h63, 7'h67, 7'h6F, 7'h73, 7'h73};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    mq.delete(); m_rdy = 1'b1;
    @(negedge clk);
    tick(); tick();
    // Reset state
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst out_pc", out_pc, 32'd0);
    chk("rst fields", {out_opcode, out_rd, out_rs1, out_rs2, out_funct3},
        32'd0);
    chk("rst imm", {out_imm_i, out_imm_u}, 32'd0);
    chk("rst sel/ill", {28'b0, out_imm_sel, out_illegal}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ADDI x1,x0,5: one-cycle latency
    out_ready = 1'b1;
    send(32'h00500093, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("addi valid", {31'b0, out_valid}, 32'd1);
    chk("addi sel", {29'b0, out_imm_sel}, 32'd1);
    chk("addi rd", {27'b0, out_rd}, 32'd1);
    chk("addi imm_i", {20'b0, out_imm_i}, 32'h005);
    chk("addi ill", {31'b0, out_illegal}, 32'd0);
    tick();

    // Four back-to-back with out_ready high
    for (int k = 0; k < 4; k++) begin
      send(32'h00000013 | (k << 7), 32'h200 + 4 * k);
      tick();
      chk("stream in_ready", {31'b0, in_ready}, 32'd1);
      chk("stream pc", out_pc, 32'h200 + 4 * k);
    end
    in_valid = 1'b0;
    tick();
    chk("stream drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: two held, third ignored, both drain in order
    out_ready = 1'b0;
    send(32'h00100113, 32'h300); tick();
    send(32'h00200193, 32'h304); tick();
    chk("bp in_ready low", {31'b0, in_ready}, 32'd0);
    send(32'h00300213, 32'h308); tick();   // must be ignored
    chk("bp hold pc", out_pc, 32'h300);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp second pc", out_pc, 32'h304);
    chk("bp in_ready back", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp empty", {31'b0, out_valid}, 32'd0);

    // Flush with main and skid full plus a simultaneous input
    out_ready = 1'b0;
    send(32'h00400293, 32'h400); tick();
    send(32'h00500313, 32'h404); tick();
    flush = 1'b1;
    send(32'h00600393, 32'h408); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush no replay", {31'b0, out_valid}, 32'd0);
    end

    // Flush beats a transfer into an empty stage
    flush = 1'b1;
    send(32'h00700413, 32'h500); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush vs xfer", {31'b0, out_valid}, 32'd0);

    // Vector table, one instruction at a time
    for (int v = 0; v < vt.size(); v++) begin
      send(vt[v].instr, 32'h1000 + 4 * v);
      tick();
      in_valid = 1'b0;
      chk("vec sel", {29'b0, out_imm_sel}, {29'b0, vt[v].sel});
      chk("vec ill", {31'b0, out_illegal}, {31'b0, vt[v].ill});
      if (vt[v].instr == 32'h00112023)
        chk("sw imm hi/lo", {20'b0, out_imm_hi, out_imm_lo}, 32'd0);
      if (vt[v].instr == 32'h12345037)
        chk("lui imm_u", {12'b0, out_imm_u}, 32'h12345);
      tick();
    end

    // Reset with the skid full discards both entries
    out_ready = 1'b0;
    send(32'h00800493, 32'h600); tick();
    send(32'h00900513, 32'h604); tick();
    in_valid = 1'b0;
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("rst skid out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst skid in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("rst no replay", {31'b0, out_valid}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(3) != 0) r[6:0] = opcs[$urandom_range(11)];
      in_valid  = ($urandom_range(3) != 0);
      in_instr  = r;
      in_pc     = $urandom;
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
